// File: rtl/dot_mac_stream.sv
// Streaming Q8.8 dot-product engine: LANES parallel multipliers, registered adder tree,
// cross-beat accumulator. Define DOT_MAC_SAT_EN for saturating accumulation with sat_flag.
module dot_mac_stream #(
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int ACC_W = 38
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   a_pack,
  input  logic [LANES*DW-1:0]   b_pack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      sum_out,
  output logic                  sat_flag
);

  localparam int L  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int NP = 1 << L;
  localparam int TW = 2 * DW + L;

  // Handshakes: a beat transfers on in_valid && in_ready, a result on out_valid && out_ready.
  // An unconsumed result stalls every stage, so nothing is ever dropped or overwritten.
  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign advance  = en && !stall;
  assign in_ready = en && !stall && !rst;

  // Lane products, padded with zero lanes up to the next power of two.
  logic signed [2*DW-1:0] leaf [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) leaf[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      leaf[i] = (2*DW)'($signed(a_pack[i*DW +: DW])) * (2*DW)'($signed(b_pack[i*DW +: DW]));
    end
  end

  for (genvar j = 0; j <= L; j++) begin : g_lvl
    logic signed [2*DW+j-1:0] s [NP >> j];
    logic                     v;
    logic                     lst;

    if (j == 0) begin : g_leaf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < NP; k++) s[k] <= '0;
          v   <= 1'b0;
          lst <= 1'b0;
        end else if (advance) begin
          for (int k = 0; k < NP; k++) s[k] <= leaf[k];
          v   <= in_valid;
          lst <= in_valid && in_last;
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < (NP >> j); k++) s[k] <= '0;
          v   <= 1'b0;
          lst <= 1'b0;
        end else if (advance) begin
          for (int k = 0; k < (NP >> j); k++) begin
            s[k] <= (2*DW+j)'(g_lvl[j-1].s[2*k]) + (2*DW+j)'(g_lvl[j-1].s[2*k+1]);
          end
          v   <= g_lvl[j-1].v;
          lst <= g_lvl[j-1].lst;
        end
      end
    end
  end

  logic                    tree_v;
  logic                    tree_last;
  logic signed [TW-1:0]    tree_sum;
  logic signed [ACC_W-1:0] tree_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_c;

  assign tree_v    = g_lvl[L].v;
  assign tree_last = g_lvl[L].lst;
  assign tree_sum  = g_lvl[L].s[0];
  assign tree_ext  = ACC_W'(tree_sum);

`ifdef DOT_MAC_SAT_EN
  logic                  ovf;
  logic                  ovf_c;
  logic signed [ACC_W:0] wide;

  // One guard bit exposes overflow; clip to the nearest representable extreme.
  always_comb begin
    wide  = {acc[ACC_W-1], acc} + {tree_ext[ACC_W-1], tree_ext};
    sum_c = wide[ACC_W-1:0];
    ovf_c = ovf;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum_c = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      ovf_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      sat_flag <= 1'b0;
    end else if (advance && tree_v) begin
      if (tree_last) begin
        sat_flag <= ovf_c;
        ovf      <= 1'b0;
      end else begin
        ovf      <= ovf_c;
      end
    end
  end
`else
  always_comb sum_c = acc + tree_ext;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (advance && tree_v) begin
        if (tree_last) begin
          sum_out <= sum_c;
          acc     <= '0;
        end else begin
          acc     <= sum_c;
        end
      end
      // The output side is served even with en low.
      if (advance && tree_v && tree_last) out_valid <= 1'b1;
      else if (out_ready)                 out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_mac_stream.sv
// Directed bench for dot_mac_stream: default instance (ACC_W=38) plus an ACC_W=34 instance
// for the overflow scenario; expectations follow DOT_MAC_SAT_EN when it is defined.
module tb_dot_mac_stream;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int ACC_W = 38;
  localparam int PW    = LANES * DW;

  logic             clk;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [PW-1:0]    a_pack;
  logic [PW-1:0]    b_pack;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum_out;
  logic             sat_flag;

  logic             in_ready_s;
  logic             out_valid_s;
  logic [33:0]      sum_s;
  logic             sat_s;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  logic [ACC_W-1:0] exp_q[$];

  dot_mac_stream #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_pack(a_pack), .b_pack(b_pack), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .sat_flag(sat_flag)
  );

  dot_mac_stream #(.LANES(LANES), .DW(DW), .ACC_W(34)) dut_s (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_last(in_last), .a_pack(a_pack), .b_pack(b_pack), .out_valid(out_valid_s),
    .out_ready(out_ready), .sum_out(sum_s), .sat_flag(sat_s)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every delivered result must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sum_out", sum_out, exp_q.pop_front());
    end
  end

  function automatic logic [PW-1:0] fill(input logic [DW-1:0] v);
    logic [PW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic send_beat(input logic [PW-1:0] pa, input logic [PW-1:0] pb,
                           input logic last, input string tag);
    logic ok;
    a_pack   = pa;
    b_pack   = pb;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    check({tag, "_accept"}, ok, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Latency counted in clock edges, the accepting edge of ref_c being edge 1.
  task automatic wait_valid(input int ref_c, input string tag, output int lat);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_seen"}, out_valid, 1);
    lat = cyc - ref_c + 1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  int          lat;
  int          lat_ref;
  int          c0;
  int          aq [56];
  int          bq [56];
  longint      ramp_sum;
  logic [PW-1:0] pa;
  logic [PW-1:0] pb;
  logic [33:0] e34;
  logic        e34_sat;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a_pack    = '0;
    b_pack    = '0;
    out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_sat_flag", sat_flag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single beat 1.0*2.0 over 8 lanes = 16.0, latency 5
    exp_q.push_back(ACC_W'(64'h10_0000));
    send_beat(fill(16'h0100), fill(16'h0200), 1'b1, "t1");
    wait_valid(acc_cyc, "t1", lat);
    check("t1_latency", lat, 5);
    drain("t1");

    // 2a: three beats of -1.5*0.5 = -18.0
    exp_q.push_back(ACC_W'(-64'sd1179648));
    send_beat(fill(16'hFE80), fill(16'h0080), 1'b0, "t2a_b0");
    send_beat(fill(16'hFE80), fill(16'h0080), 1'b0, "t2a_b1");
    send_beat(fill(16'hFE80), fill(16'h0080), 1'b1, "t2a_b2");
    drain("t2a");

    // 2b: 49-element ramp over 7 beats, lanes 49..55 zero
    ramp_sum = 0;
    for (int i = 0; i < 56; i++) begin
      if (i < 49) begin
        aq[i] = $rtoi((i * 2.37 - 11.125) * 256.0);
        bq[i] = $rtoi((6.832 - i * 0.173) * 256.0);
      end else begin
        aq[i] = 0;
        bq[i] = 0;
      end
      ramp_sum += longint'(aq[i]) * longint'(bq[i]);
    end
    exp_q.push_back(ACC_W'(ramp_sum));
    for (int bt = 0; bt < 7; bt++) begin
      for (int l = 0; l < LANES; l++) begin
        pa[l*DW +: DW] = DW'(aq[bt*LANES + l]);
        pb[l*DW +: DW] = DW'(bq[bt*LANES + l]);
      end
      send_beat(pa, pb, bt == 6, "t2b");
    end
    drain("t2b");

    // 3: backpressure with a second vector in flight
    out_ready = 1'b0;
    exp_q.push_back(ACC_W'(64'h10_0000));
    exp_q.push_back(ACC_W'(64'h30_0000));
    exp_q.push_back(ACC_W'(64'h08_0000));
    send_beat(fill(16'h0100), fill(16'h0200), 1'b1, "t3_x");
    c0 = acc_cyc;
    send_beat(fill(16'h0100), fill(16'h0300), 1'b0, "t3_y0");
    send_beat(fill(16'h0100), fill(16'h0300), 1'b1, "t3_y1");
    wait_valid(c0, "t3_x", lat);
    a_pack   = fill(16'h0100);
    b_pack   = fill(16'h0100);
    in_last  = 1'b1;
    in_valid = 1'b1;
    check("t3_in_ready_stalled", in_ready, 0);
    check("t3_sum_held", sum_out, ACC_W'(64'h10_0000));
    repeat (6) @(negedge clk);
    check("t3_in_ready_still", in_ready, 0);
    check("t3_sum_still", sum_out, ACC_W'(64'h10_0000));
    check("t3_valid_still", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_beat(fill(16'h0100), fill(16'h0100), 1'b1, "t3_z");
    drain("t3");

    // 4: two-beat 32.0 vector, reference then with en low for 5 cycles mid-vector
    exp_q.push_back(ACC_W'(64'h20_0000));
    send_beat(fill(16'h0100), fill(16'h0200), 1'b0, "t4r_b0");
    c0 = acc_cyc;
    send_beat(fill(16'h0100), fill(16'h0200), 1'b1, "t4r_b1");
    wait_valid(c0, "t4r", lat_ref);
    check("t4_ref_latency", lat_ref, 6);
    drain("t4r");

    exp_q.push_back(ACC_W'(64'h20_0000));
    send_beat(fill(16'h0100), fill(16'h0200), 1'b0, "t4e_b0");
    c0 = acc_cyc;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    send_beat(fill(16'h0100), fill(16'h0200), 1'b1, "t4e_b1");
    wait_valid(c0, "t4e", lat);
    check("t4_en_latency", lat, 11);
    drain("t4e");

    // 5: overflow on the ACC_W=34 instance; 38-bit instance holds the exact value
`ifdef DOT_MAC_SAT_EN
    e34     = 34'h1_FFFF_FFFF;
    e34_sat = 1'b1;
`else
    e34     = 34'h3_FFF0_0010;
    e34_sat = 1'b0;
`endif
    exp_q.push_back(ACC_W'(64'h3_FFF0_0010));
    send_beat(fill(16'h7FFF), fill(16'h7FFF), 1'b0, "t5_b0");
    c0 = acc_cyc;
    send_beat(fill(16'h7FFF), fill(16'h7FFF), 1'b1, "t5_b1");
    wait_valid(c0, "t5", lat);
    check("t5_narrow_sum", sum_s, e34);
    check("t5_narrow_sat", sat_s, e34_sat);
    check("t5_wide_sat", sat_flag, 0);
    drain("t5");

    // 6: reset after two of three beats, then a fresh single-beat vector
    send_beat(fill(16'hFE80), fill(16'h0080), 1'b0, "t6_b0");
    send_beat(fill(16'hFE80), fill(16'h0080), 1'b0, "t6_b1");
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_sum_out", sum_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(ACC_W'(64'h10_0000));
    send_beat(fill(16'h0100), fill(16'h0200), 1'b1, "t6_fresh");
    c0 = acc_cyc;
    wait_valid(c0, "t6", lat);
    check("t6_latency", lat, 5);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_mac_stream.md
Name: dot_mac_stream

Overview:
- Streaming, parametrised Q8.8 dot-product engine; successor to the fixed N-lane `top` MAC array.
- Accepts LANES element pairs per beat over a valid/ready handshake and multiplies them in parallel.
- Reduces the products through a registered adder tree and accumulates across beats until `in_last`.
- Emits one Q(ACC_W-16).16 result per vector, so vectors longer than LANES (e.g. 49 elements on 8 lanes) run without a 49-multiplier array.

Parameters:
- LANES, 8, multipliers per beat (>=1; non-power-of-2 allowed, tree pads with zeros).
- DW, 16, element width, signed Q8.8.
- ACC_W, 38, accumulator/result width, signed Q(ACC_W-16).16 (>= 2*DW + clog2(LANES)).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, pipeline enable; low freezes all internal stages.
- in_valid, in, 1, beat valid.
- in_ready, out, 1, beat accepted when in_valid && in_ready.
- in_last, in, 1, marks final beat of a vector.
- a_pack, in, LANES*DW, lane i at [i*DW +: DW], signed Q8.8.
- b_pack, in, LANES*DW, same layout as a_pack.
- out_valid, out, 1, sum_out holds a result.
- out_ready, in, 1, consumer accepts when out_valid && out_ready.
- sum_out, out, ACC_W, signed Q(ACC_W-16).16 dot product.
- sat_flag, out, 1, result saturated (only with macro; else 0).

Behaviour:
- Reset (async, rst=1): all stage valid bits 0, accumulator 0, sum_out 0, out_valid 0, sat_flag 0, in_ready 0. Takes effect immediately and discards any partial vector.
- Pipeline, L = clog2(LANES):
  - Stage P: registers LANES signed products, 2*DW bits each, Q16.16, exact.
  - Stages T1..TL: registered pairwise adds, each level widened by 1 bit.
  - Stage A: accumulator plus output register.
  - Each stage carries a valid and a last bit.
- Stall: stall = out_valid && !out_ready. Stages advance only when en && !stall. in_ready = en && !stall && !rst.
- Stage A, non-last beat: acc <= acc + tree_sum (sign-extended to ACC_W).
- Stage A, last beat:
  - sum_out <= acc + tree_sum; out_valid <= 1; acc <= 0.
  - A next vector may follow back-to-back with no bubble.
- Latency: out_valid rises L+2 cycles after acceptance of the last beat (LANES=8: 5 cycles), assuming en=1 and no stall.
- Throughput: one beat per cycle.
- Output handshake:
  - out_valid clears on out_ready unless a new result loads the same cycle; simultaneous pop and load is legal and keeps out_valid=1.
  - The output handshake is honoured even when en=0.
  - sum_out is stable while out_valid && !out_ready.
- Overflow without the macro: two's-complement wrap at ACC_W bits.
- Bubbles (in_valid=0) insert invalid slots; stage A ignores them, and the accumulator holds.
- A vector of one beat with in_last=1 is legal. Beats with in_valid=0 carry no meaning for in_last.

Optional Feature:
- Macro: DOT_MAC_SAT_EN.
- Defined:
  - Each accumulate/final add is saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky per-vector overflow bit is set on any clip. It is copied into sat_flag with sum_out and cleared at vector start.
  - Once saturated, later beats continue from the clipped value.
- Undefined: wrap arithmetic as above; sat_flag tied 0.
- Port list is identical in both builds.

Test Plan:
1. LANES=8, all a=0x0100 (1.0), b=0x0200 (2.0), single beat, in_last=1 -> sum_out=0x100000 (16.0), out_valid exactly 5 cycles after acceptance.
2. 3-beat vector, all lanes a=0xFE80 (-1.5), b=0x0080 (0.5) -> sum_out=-1179648 (-18.0). Then 49-element ramp a_i=i*2.37-11.125, b_i=6.832-i*0.173 over 7 beats (lanes 49..55 zero) -> sum_out matches the exact sum of Q8.8-truncated products bit-for-bit.
3. Backpressure: out_ready=0 with a result pending and a second vector streaming -> in_ready=0, first sum_out held unchanged. Release out_ready -> both results delivered in order, none lost or duplicated.
4. en=0 for 5 cycles mid-vector (scenario-1 data, 2 beats) -> sum_out=32.0, out_valid delayed by exactly 5 cycles versus the en=1 run.
5. ACC_W=34, two beats with all lanes a=b=0x7FFF:
   - With DOT_MAC_SAT_EN -> sum_out=2^33-1, sat_flag=1.
   - Without -> sum_out = 17178820624 mod 2^34 interpreted signed, sat_flag=0.
6. rst pulsed after 2 of 3 beats, then a fresh single-beat vector of scenario 1 -> sum_out=16.0 (no residue), out_valid=0 during reset.
